gic_master: RTL and testbench

Gris InterConnect master: a Wishbone classic slave that serializes each accepted bus cycle onto the 4-bit GIC link and waits for the remote GIC slave's response. It sits on the local Wishbone bus and drives the GIC link toward the remote GIC slave, which replays the cycle as a Wishbone master. Read data and termination status return over the same link. The block completes the local cycle with ack, err or rty.

---
 rtl/gic_master.sv | 212 +++++++++++++++++++++
 tb/tb_gic_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gic_master.sv
// gic_master: Wishbone classic slave that forwards each accepted bus cycle
// to a remote GIC slave over a 4-bit nibble link. It then completes the local
// cycle with ack, err or rty, according to the remote response.
//
// Ports:
//   wbs_clk_i, wbs_rst_i     clock, asynchronous active-high reset
//   wbs_adr_i/dat_i/sel_i    request address, write data, byte selects
//   wbs_we_i/cyc_i/stb_i     Wishbone control
//   wbs_cti_i/bte_i          ignored (classic cycles only)
//   wbs_dat_o                read data, held until the next read
//   wbs_ack_o/err_o/rty_o    single-clock termination pulses
//   gic_dat_o                registered link nibble toward the GIC slave
//   gic_dat_i                link nibble from the GIC slave
module gic_master #(
  parameter logic [3:0] idle    = 4'b1111,
  parameter int         timeout = 255
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [3:0]  gic_dat_o,
  input  logic [3:0]  gic_dat_i
);

  localparam logic [3:0]  MST_INIT = 4'b1010;
  localparam logic [3:0]  SLV_INIT = 4'b0101;
  localparam logic [3:0]  WORD_END = 4'b1100;
  localparam logic [15:0] TMO_LAST = 16'(timeout - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, CMD, SEL, ADR, DAT, CKSUM, WAIT, RESP, RDAT, RCKS, DONE
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [2:0]  cnt_m1;
  logic [15:0] wcnt;
  logic        we_q;
  logic [3:0]  resp_q;
  logic [3:0]  rcs;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [3:0]  req_csum;
  logic        req;
  logic        accept;
  logic        unused_ok;

  // XOR of the eight nibbles of a 32-bit word.
  function automatic logic [3:0] xor_nib(input logic [31:0] w);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 8; i++) r = r ^ w[4*i +: 4];
    return r;
  endfunction

  // Remote response nibble to {rty, err, ack}; anything not one-hot is err.
  function automatic logic [2:0] decode_resp(input logic [3:0] r);
    case (r)
      4'b0001: return 3'b001;
      4'b0100: return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  assign unused_ok = ^{wbs_cti_i, wbs_bte_i};
  assign req       = wbs_cyc_i & wbs_stb_i;
  // Termination still showing means the previous cycle is being closed.
  assign accept    = req & ~(wbs_ack_o | wbs_err_o | wbs_rty_o);
  assign cnt_m1    = cnt - 3'd1;

  // Request checksum from the latched cycle; the cmd nibble does not take part.
  assign req_csum = sel_q ^ xor_nib(adr_q) ^ WORD_END ^
                    (we_q ? (xor_nib(dat_q) ^ WORD_END) : 4'h0);

  // Latched request payload (no reset needed: only read after a latch).
  always_ff @(posedge wbs_clk_i) begin
    if (state == IDLE && accept) begin
      adr_q <= wbs_adr_i;
      dat_q <= wbs_dat_i;
      sel_q <= wbs_sel_i;
    end
  end

  // Main FSM; gic_dat_o is loaded with the nibble of the state being entered.
  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      wcnt      <= 16'd0;
      we_q      <= 1'b0;
      resp_q    <= 4'h0;
      rcs       <= 4'h0;
      wbs_dat_o <= 32'h0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_rty_o <= 1'b0;
      gic_dat_o <= idle;
    end else begin
      case (state)
        IDLE: begin
          gic_dat_o <= idle;
          if (accept) begin
            we_q      <= wbs_we_i;
            state     <= INIT;
            gic_dat_o <= MST_INIT;
          end
        end
        INIT: begin
          state     <= CMD;
          gic_dat_o <= {we_q, 3'b000};
        end
        CMD: begin
          state     <= SEL;
          gic_dat_o <= sel_q;
        end
        SEL: begin
          state     <= ADR;
          cnt       <= 3'd7;
          gic_dat_o <= adr_q[31:28];
        end
        ADR: begin
          if (cnt == 3'd0) begin
            if (we_q) begin
              state     <= DAT;
              cnt       <= 3'd7;
              gic_dat_o <= dat_q[31:28];
            end else begin
              state     <= CKSUM;
              gic_dat_o <= req_csum;
            end
          end else begin
            cnt       <= cnt_m1;
            gic_dat_o <= adr_q[{cnt_m1, 2'b00} +: 4];
          end
        end
        DAT: begin
          if (cnt == 3'd0) begin
            state     <= CKSUM;
            gic_dat_o <= req_csum;
          end else begin
            cnt       <= cnt_m1;
            gic_dat_o <= dat_q[{cnt_m1, 2'b00} +: 4];
          end
        end
        CKSUM: begin
          state     <= WAIT;
          wcnt      <= 16'd0;
          gic_dat_o <= idle;
        end
        WAIT: begin
          gic_dat_o <= idle;
          if (gic_dat_i == SLV_INIT) begin
            state <= RESP;
          end else if (wcnt == TMO_LAST) begin
            state     <= DONE;
            wbs_err_o <= req;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        RESP: begin
          resp_q <= gic_dat_i;
          // The slave always sends read data, whatever the response code.
          if (we_q) begin
            state <= DONE;
            {wbs_rty_o, wbs_err_o, wbs_ack_o} <= req ? decode_resp(gic_dat_i) : 3'b000;
          end else begin
            state <= RDAT;
            cnt   <= 3'd7;
            rcs   <= 4'h0;
          end
        end
        RDAT: begin
          wbs_dat_o <= {wbs_dat_o[27:0], gic_dat_i};
          rcs       <= rcs ^ gic_dat_i;
          if (cnt == 3'd0) state <= RCKS;
          else             cnt   <= cnt_m1;
        end
        RCKS: begin
          state <= DONE;
          if (!req)
            {wbs_rty_o, wbs_err_o, wbs_ack_o} <= 3'b000;
          else if (gic_dat_i != (rcs ^ WORD_END))
            {wbs_rty_o, wbs_err_o, wbs_ack_o} <= 3'b010;
          else
            {wbs_rty_o, wbs_err_o, wbs_ack_o} <= decode_resp(resp_q);
        end
        DONE: begin
          state <= IDLE;
          {wbs_rty_o, wbs_err_o, wbs_ack_o} <= 3'b000;
        end
        default: begin
          state     <= IDLE;
          gic_dat_o <= idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gic_master.sv
// Directed bench for gic_master: plays the remote GIC slave by hand and
// checks the request nibble stream, the response handling and terminations.
module tb_gic_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack, err, rty;
  logic [3:0]  gic_o, gic_i;
  logic [2:0]  term;

  int n_tests = 0;
  int n_fail  = 0;

  gic_master #(.idle(4'b1111), .timeout(16)) dut (
    .wbs_clk_i(clk),
    .wbs_rst_i(rst),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_sel_i(sel),
    .wbs_we_i (we),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_cti_i(cti),
    .wbs_bte_i(bte),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_rty_o(rty),
    .gic_dat_o(gic_o),
    .gic_dat_i(gic_i)
  );

  always #5 clk = ~clk;

  assign term = {rty, err, ack};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a cycle at a negedge in IDLE and checks every request nibble.
  task automatic request(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] cks, input string tag);
    we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(negedge clk) chk({tag, " init"}, gic_o, 4'b1010);
    @(negedge clk) chk({tag, " cmd"}, gic_o, {w, 3'b000});
    @(negedge clk) chk({tag, " sel"}, gic_o, s);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) chk({tag, " adr"}, gic_o, a[31-4*k -: 4]);
    end
    if (w) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk) chk({tag, " dat"}, gic_o, d[31-4*k -: 4]);
      end
    end
    @(negedge clk) chk({tag, " cks"}, gic_o, cks);
  endtask

  // Sends the slave response from WAIT and checks the termination pulse.
  task automatic respond(input logic rd, input logic [3:0] resp, input logic [31:0] d,
                         input logic [3:0] cks, input logic [2:0] exp_term, input string tag);
    @(negedge clk) chk({tag, " wait idle"}, gic_o, 4'b1111);
    gic_i = 4'b0101;
    @(negedge clk) gic_i = resp;
    if (rd) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk) gic_i = d[31-4*k -: 4];
      end
      @(negedge clk) gic_i = cks;
    end
    @(negedge clk) gic_i = 4'b1111;
    chk({tag, " term"}, term, exp_term);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) chk({tag, " term end"}, term, 3'b000);
  endtask

  initial begin
    int good;
    rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b000; bte = 2'b00; gic_i = 4'b1111;

    @(negedge clk);
    chk("rst gic", gic_o, 4'b1111);
    chk("rst term", term, 3'b000);
    chk("rst dat_o", dat_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write: sel F ^ adr(9) ^ C ^ data(0) ^ C = 6 (cmd nibble not included).
    request(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h6, "wr");
    respond(1'b0, 4'b0001, 32'h0, 4'h0, 3'b001, "wr");

    // Read: request checksum 3 ^ 4 ^ C = B; response checksum 8 ^ C = 4.
    request(1'b0, 32'h0000_0004, 32'h0, 4'h3, 4'hB, "rd");
    respond(1'b1, 4'b0001, 32'h1234_5678, 4'h4, 3'b001, "rd");
    chk("rd dat_o", dat_o, 32'h1234_5678);

    // Read with corrupted response checksum.
    request(1'b0, 32'h0000_0004, 32'h0, 4'h3, 4'hB, "rdbad");
    respond(1'b1, 4'b0001, 32'h1234_5678, 4'h5, 3'b010, "rdbad");

    // Timeout: 16 WAIT clocks with idle link, then err.
    request(1'b0, 32'h0000_0004, 32'h0, 4'h3, 4'hB, "tmo");
    good = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gic_o === 4'b1111 && term === 3'b000) good++;
    end
    chk("tmo wait", good, 16);
    @(negedge clk) chk("tmo term", term, 3'b010);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) chk("tmo term end", term, 3'b000);

    // Response codes on all-zero writes: checksum F ^ C ^ C = F.
    request(1'b1, 32'h0, 32'h0, 4'hF, 4'hF, "r0100");
    respond(1'b0, 4'b0100, 32'h0, 4'h0, 3'b100, "r0100");
    request(1'b1, 32'h0, 32'h0, 4'hF, 4'hF, "r0000");
    respond(1'b0, 4'b0000, 32'h0, 4'h0, 3'b010, "r0000");
    request(1'b1, 32'h0, 32'h0, 4'hF, 4'hF, "r0011");
    respond(1'b0, 4'b0011, 32'h0, 4'h0, 3'b010, "r0011");

    // Asynchronous reset in the middle of the address phase.
    we = 1'b1; adr = 32'h8000_0010; dat = 32'hDEAD_BEEF; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre-rst adr", gic_o, 4'h0);
    rst = 1'b1;
    #1;
    chk("async rst gic", gic_o, 4'b1111);
    chk("async rst term", term, 3'b000);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-rst gic", gic_o, 4'b1111);
    chk("post-rst term", term, 3'b000);

    request(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 4'h6, "wr2");
    respond(1'b0, 4'b0001, 32'h0, 4'h0, 3'b001, "wr2");

    // cyc dropped during WAIT: link completes, no termination.
    request(1'b1, 32'h0, 32'h0, 4'hF, 4'hF, "drop");
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    respond(1'b0, 4'b0001, 32'h0, 4'h0, 3'b000, "drop");
    @(negedge clk) chk("drop idle", gic_o, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
